mmio_arbiter: RTL and testbench
===============================

Name: mmio_arbiter

Overview:
Shares the single mmio load/store port (RAM, VRAM, keyboard, clock counter, LEDs) between two requesters. Requester 0 is the CPU data port; requester 1 is the loader/DMA engine. Sits between the requesters and mmio. Each access is registered and driven onto the bus for exactly one cycle, so side-effecting reads (keyboard pop) fire once per transaction. Arbitration is fixed priority to requester 0, with a starvation override for requester 1.

Parameters:
STARVE_LIMIT, 8, consecutive cycles req1 may wait while req0 wins before req1 is forced to win (1..255)
CNT_W, 8, width of the starvation counter

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-low reset
req0 / req1  in  1  request valid, held until matching gnt
we0 / we1  in  1  1 = store, 0 = load
access0 / access1  in  3  funct3 access code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
addr0 / addr1  in  32  byte address
wdata0 / wdata1  in  32  store data
gnt0 / gnt1  out  1  one-cycle pulse: request latched, inputs may change next cycle
rvalid0 / rvalid1  out  1  one-cycle pulse: transaction complete
rdata0 / rdata1  out  32  load data, valid with rvalid; 0 for stores
bus_load  out  1  to mmio load
bus_store  out  1  to mmio store
bus_access  out  3  to mmio access
bus_addr  out  32  to mmio addr
bus_wdata  out  32  to mmio data_in
bus_rdata  in  32  from mmio data_out

Behaviour:
- Reset (rst=0, async): state=IDLE; all gnt/rvalid=0; bus_load=bus_store=0; bus_access=0, bus_addr=0, bus_wdata=0; rdata0/1=0; starvation counter=0; owner=0. A transaction in flight is dropped with no rvalid.
- FSM: IDLE, ISSUE, RESP.
- Arbitration runs in IDLE and RESP:
  - Winner is req1 if req1 && (!req0 || starve_cnt==STARVE_LIMIT); else req0 if asserted.
  - On a win: latch we/access/addr/wdata and owner into registers, pulse gnt for the winner in the same cycle, next state ISSUE.
  - With no request: IDLE→IDLE, RESP→IDLE.
- ISSUE, exactly one cycle:
  - bus_load = !we_r, bus_store = we_r; bus_access/addr/wdata driven from latched registers.
  - Next state is RESP.
  - bus_load and bus_store are 0 in every state other than ISSUE.
- RESP:
  - Capture bus_rdata into the owner's rdata (0 if store) and pulse the owner's rvalid.
  - Arbitrate for the next transaction in the same cycle (back-to-back throughput: one access per 2 cycles).
- Latency: gnt at cycle T, bus strobe at T+1, rvalid and rdata at T+2.
- rdata holds its value until that requester's next rvalid.
- gnt is combinational from state and req. rvalid, rdata and bus_* are registered.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) in each arbitration cycle where req1=1 and req0 wins.
  - Clears when req1 is granted or req1=0.
  - Does not change in ISSUE.
- Simultaneous events:
  - req0 and req1 together, counter below limit → gnt0 only.
  - At the limit → gnt1 only.
  - Only one gnt is ever high per cycle.
- A requester must not deassert req before gnt. Dropping it early is a protocol violation; the arbiter only samples req at arbitration.
- The owner's rvalid and a new gnt to the same requester may coincide in RESP.

Decomposition:
- Package mmio_pkg:
  - Access codes ACC_LB=3'b000, ACC_LH=3'b001, ACC_LW=3'b010, ACC_LBU=3'b100, ACC_LHU=3'b101.
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - MMIO address constants: KBD_DATA=32'hfbadbeef, KBD_READY=32'hfbadbeee, CLK_CNT=32'hfbadbedf, LED=32'hfbadc0fe, VRAM_BASE=32'hfbad0000.
- One sub-module, arb_starve_cnt: saturating starvation counter with inc/clr inputs and an at_limit output.

Test Plan:
- Reset mid-transaction: req0 load addr 0x100 granted, assert rst=0 during ISSUE → bus_load falls immediately, no rvalid0, state IDLE after release.
- Single load: req0, we0=0, access0=010, addr0=0x40, RAM holds 0xDEADBEEF → gnt0 at T, bus_load=1 at T+1 only, rvalid0=1 with rdata0=0xDEADBEEF at T+2.
- Single store: req1, we1=1, access1=010, addr1=0xfbadc0fe, wdata1=0x5A → bus_store=1 for one cycle with bus_wdata=0x5A, rvalid1 with rdata1=0.
- Contention: req0 and req1 held continuously, STARVE_LIMIT=3 → grant sequence 0,0,0,1,0,0,0,1; never two gnt in one cycle.
- Keyboard pop: req0 lbu addr 0xfbadbeef held for 3 back-to-back transactions → exactly 3 single-cycle bus_load strobes, 2 cycles apart.
- Back-to-back: req0 then req1 queued → RESP of req0 coincides with gnt1; rvalid1 4 cycles after gnt0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the mmio port arbiter: access codes,
// arbiter FSM encoding, well-known mmio addresses and the latched request payload.
package mmio_pkg;

  localparam logic [2:0] ACC_LB  = 3'b000;
  localparam logic [2:0] ACC_LH  = 3'b001;
  localparam logic [2:0] ACC_LW  = 3'b010;
  localparam logic [2:0] ACC_LBU = 3'b100;
  localparam logic [2:0] ACC_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] KBD_DATA  = 32'hfbadbeef;
  localparam logic [31:0] KBD_READY = 32'hfbadbeee;
  localparam logic [31:0] CLK_CNT   = 32'hfbadbedf;
  localparam logic [31:0] LED       = 32'hfbadc0fe;
  localparam logic [31:0] VRAM_BASE = 32'hfbad0000;

  typedef struct packed {
    logic        we;
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mmio_req_t;

  function automatic mmio_req_t pack_req(input logic we, input logic [2:0] access,
                                         input logic [31:0] addr, input logic [31:0] wdata);
    mmio_req_t r;
    r.we     = we;
    r.access = access;
    r.addr   = addr;
    r.wdata  = wdata;
    return r;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of arbitration rounds requester 1 has lost; at_limit is
// registered so it describes the count seen by the next arbitration round.
module arb_starve_cnt #(
  parameter int unsigned LIMIT = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit_q, at_limit_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    at_limit_d = (cnt_d == CNT_W'(LIMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      at_limit_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign at_limit = at_limit_q;

endmodule

// File: rtl/mmio_arbiter.sv
// Two-requester arbiter in front of the single mmio load/store port. Every
// access is latched, strobed on the bus for exactly one cycle, then returned.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [2:0]  access0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [2:0]  access1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        bus_load,
  output logic        bus_store,
  output logic [2:0]  bus_access,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  arb_state_e  state_q, state_d;
  mmio_req_t   txn_q, txn_d;
  logic        owner_q, owner_d;
  logic        bus_load_q, bus_load_d;
  logic        bus_store_q, bus_store_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic arb_c, win0_c, win1_c, starve_inc_c, starve_clr_c, at_limit;

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc_c),
    .clr      (starve_clr_c),
    .at_limit (at_limit)
  );

  // Fixed priority to requester 0 unless requester 1 has waited long enough.
  always_comb begin
    arb_c        = (state_q == IDLE) || (state_q == RESP);
    win1_c       = arb_c && req1 && (!req0 || at_limit);
    win0_c       = arb_c && req0 && !win1_c;
    starve_inc_c = win0_c && req1;
    starve_clr_c = arb_c && !starve_inc_c;
  end

  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    owner_d     = owner_q;
    bus_load_d  = 1'b0;
    bus_store_d = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (win0_c || win1_c) begin
          state_d     = ISSUE;
          txn_d       = win1_c ? pack_req(we1, access1, addr1, wdata1)
                               : pack_req(we0, access0, addr0, wdata0);
          owner_d     = win1_c;
          bus_load_d  = !txn_d.we;
          bus_store_d = txn_d.we;
        end
      end
      ISSUE: begin
        // mmio answers while the strobe is up; land it in the owner's slot.
        state_d = RESP;
        if (owner_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = txn_q.we ? 32'h0 : bus_rdata;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = txn_q.we ? 32'h0 : bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      owner_q     <= 1'b0;
      bus_load_q  <= 1'b0;
      bus_store_q <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      owner_q     <= owner_d;
      bus_load_q  <= bus_load_d;
      bus_store_q <= bus_store_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign gnt0       = win0_c;
  assign gnt1       = win1_c;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign bus_load   = bus_load_q;
  assign bus_store  = bus_store_q;
  assign bus_access = txn_q.access;
  assign bus_addr   = txn_q.addr;
  assign bus_wdata  = txn_q.wdata;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: drivers issue requests, a reference model
// predicts grants and queues the bus strobe and response each grant must produce.
module tb_mmio_arbiter;
  import mmio_pkg::*;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [2:0]  access0 = '0, access1 = '0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, bus_load, bus_store;
  logic [31:0] rdata0, rdata1, bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_access;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic we; logic [2:0] acc; logic [31:0] addr; logic [31:0] wdata; int cyc; } bus_exp_t;
  typedef struct { logic [31:0] data; int cyc; } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp0_q[$];
  resp_exp_t resp1_q[$];
  int        gnt_log[$];
  int        kbd_cyc[$];
  int        waitc = 0;
  bit        busy = 1'b0;
  int        gcyc0 = 0, gcyc1 = 0, rvcyc0 = 0, rvcyc1 = 0, rv0_seen = 0;

  mmio_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .access0(access0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .access1(access1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .bus_load(bus_load), .bus_store(bus_store), .bus_access(bus_access),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory contents seen by a load: fixed test word at 0x40, address hash elsewhere.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], a[31:16]} ^ 32'h3C5A9617;
  endfunction

  assign bus_rdata = bus_load ? mem_model(bus_addr) : 32'h0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    int exp_w;
    bus_exp_t be;
    resp_exp_t re;
    if (!rst) begin
      bus_q.delete(); resp0_q.delete(); resp1_q.delete();
      waitc = 0; busy = 1'b0;
    end else begin
      if (bus_load || bus_store) begin
        if (bus_load && bus_addr == KBD_DATA) kbd_cyc.push_back(cyc);
        if (bus_q.size() == 0) chk("bus_unexpected", {bus_store, bus_load}, 64'h0);
        else begin
          be = bus_q.pop_front();
          chk("bus_kind", {bus_store, bus_load, bus_access}, {be.we, !be.we, be.acc});
          chk("bus_addr", bus_addr, be.addr);
          chk("bus_wdata", bus_wdata, be.wdata);
          chk("bus_cycle", cyc, be.cyc);
        end
      end
      if (rvalid0) begin
        rv0_seen++; rvcyc0 = cyc;
        if (resp0_q.size() == 0) chk("rvalid0_unexpected", 1, 0);
        else begin
          re = resp0_q.pop_front();
          chk("rdata0", rdata0, re.data);
          chk("rvalid0_cycle", cyc, re.cyc);
        end
      end
      if (rvalid1) begin
        rvcyc1 = cyc;
        if (resp1_q.size() == 0) chk("rvalid1_unexpected", 1, 0);
        else begin
          re = resp1_q.pop_front();
          chk("rdata1", rdata1, re.data);
          chk("rvalid1_cycle", cyc, re.cyc);
        end
      end
      if (gnt0) gcyc0 = cyc;
      if (gnt1) gcyc1 = cyc;

      // The cycle after any grant the port is busy; otherwise decide a winner.
      exp_w = -1;
      if (!busy) begin
        if (req1 && (!req0 || waitc == LIMIT)) begin exp_w = 1; waitc = 0; end
        else if (req0) begin
          exp_w = 0;
          waitc = req1 ? ((waitc < LIMIT) ? waitc + 1 : LIMIT) : 0;
        end else waitc = 0;
      end
      chk("gnt", {gnt1, gnt0}, {exp_w == 1, exp_w == 0});
      if (exp_w == 0) begin
        bus_q.push_back('{we0, access0, addr0, wdata0, cyc + 1});
        resp0_q.push_back('{we0 ? 32'h0 : mem_model(addr0), cyc + 2});
      end else if (exp_w == 1) begin
        bus_q.push_back('{we1, access1, addr1, wdata1, cyc + 1});
        resp1_q.push_back('{we1 ? 32'h0 : mem_model(addr1), cyc + 2});
      end
      if (exp_w >= 0) gnt_log.push_back(exp_w);
      busy = (exp_w >= 0);
    end
  end

  // One request/grant handshake; entered and left just after a rising edge.
  task automatic drive_txn(input int r, input logic we, input logic [2:0] acc,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int t = 0;
    if (r == 0) begin req0 = 1; we0 = we; access0 = acc; addr0 = addr; wdata0 = wdata; end
    else        begin req1 = 1; we1 = we; access1 = acc; addr1 = addr; wdata1 = wdata; end
    forever begin
      @(negedge clk);
      if ((r == 0) ? gnt0 : gnt1) break;
      if (++t > 200) begin chk("gnt_timeout", r, 64'hFF); break; end
    end
    @(posedge clk); #1;
    if (r == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic drive_n(input int r, input int n, input int max_gap, input bit kbd);
    logic [2:0] accs[5] = '{ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU};
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      case ($urandom % 6)
        0: a = KBD_READY;
        1: a = CLK_CNT;
        2: a = LED;
        3: a = VRAM_BASE + 32'($urandom % 4096);
        default: a = $urandom & 32'h0000FFFC;
      endcase
      if (kbd) drive_txn(r, 1'b0, ACC_LBU, KBD_DATA, 32'h0);
      else     drive_txn(r, 1'($urandom % 2), accs[$urandom % 5], a, $urandom);
    end
  endtask

  task automatic settle();
    repeat (4) begin @(posedge clk); end
    #1;
  endtask

  initial begin
    int exp_seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int rv_before;
    #3;
    chk("reset_gnt_rvalid", {gnt0, gnt1, rvalid0, rvalid1}, 64'h0);
    chk("reset_bus_strobe", {bus_load, bus_store, bus_access}, 64'h0);
    chk("reset_bus_addr_wdata", {bus_addr, bus_wdata}, 64'h0);
    chk("reset_rdata", {rdata0, rdata1}, 64'h0);
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #1;

    // Reset lands while the load is on the bus.
    drive_txn(0, 1'b0, ACC_LW, 32'h100, 32'h0);
    chk("issue_strobe_before_reset", bus_load, 1);
    rv_before = rv0_seen;
    rst = 0; #1;
    chk("reset_drops_strobe", {bus_load, rvalid0}, 64'h0);
    @(posedge clk); @(posedge clk); #3 rst = 1;
    settle();
    chk("reset_no_rvalid0", rv0_seen, rv_before);

    drive_txn(0, 1'b0, ACC_LW, 32'h40, 32'h0);
    settle();
    chk("load_latency", rvcyc0 - gcyc0, 2);
    chk("load_rdata_held", rdata0, 32'hDEADBEEF);

    drive_txn(1, 1'b1, ACC_LW, LED, 32'h5A);
    settle();
    chk("store_rdata_zero", rdata1, 0);

    gnt_log.delete();
    fork
      drive_n(0, 6, 0, 1'b0);
      drive_n(1, 2, 0, 1'b0);
    join
    settle();
    chk("contention_len", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("contention_order", gnt_log[i], exp_seq[i]);

    kbd_cyc.delete();
    drive_n(0, 3, 0, 1'b1);
    settle();
    chk("kbd_strobe_count", kbd_cyc.size(), 3);
    if (kbd_cyc.size() == 3) begin
      chk("kbd_spacing_a", kbd_cyc[1] - kbd_cyc[0], 2);
      chk("kbd_spacing_b", kbd_cyc[2] - kbd_cyc[1], 2);
    end

    fork
      drive_txn(0, 1'b0, ACC_LH, 32'h200, 32'h0);
      drive_txn(1, 1'b0, ACC_LHU, 32'h300, 32'h0);
    join
    settle();
    chk("b2b_gnt1_in_resp", gcyc1 - gcyc0, 2);
    chk("b2b_rvalid1", rvcyc1 - gcyc0, 4);

    fork
      drive_n(0, 40, 3, 1'b0);
      drive_n(1, 40, 3, 1'b0);
    join
    settle();
    chk("drain", bus_q.size() + resp0_q.size() + resp1_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
